// File: rtl/race_timer.sv
// race_timer: N-lane drag-race timing engine.
// Runs the start countdown, times each lane in ticks of 1/TICK_HZ s from GO
// until that lane's finish edge, ranks the winner and pulses done.
// Optional feature: define RACE_TIMER_FALSE_START_EN to disqualify any lane
// whose launch input is high during the countdown.
module race_timer #(
    parameter int PLAYERS   = 2,
    parameter int CLK_HZ    = 65_000_000,
    parameter int TICK_HZ   = 100,
    parameter int TIME_W    = 14,
    parameter int COUNTDOWN = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [PLAYERS-1:0]          finish,
    input  logic [PLAYERS-1:0]          launch,
    output logic [1:0]                  state,
    output logic [2:0]                  count_val,
    output logic                        go,
    output logic [PLAYERS*TIME_W-1:0]   times,
    output logic [PLAYERS-1:0]          finished,
    output logic [PLAYERS-1:0]          dq,
    output logic [PLAYERS-1:0]          winner,
    output logic                        done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_RACE  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SEC_W = (TICK_HZ > 1) ? $clog2(TICK_HZ) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [SEC_W-1:0]  SEC_LAST   = SEC_W'(TICK_HZ - 1);
    localparam logic [TIME_W-1:0] TIME_MAX   = '1;
    localparam logic [2:0]        COUNT_INIT = 3'(COUNTDOWN);

    state_t              state_r, state_s;
    logic [DIV_W-1:0]    div_r, div_s;
    logic [SEC_W-1:0]    sec_r, sec_s;
    logic [2:0]          count_r, count_s;
    logic                go_r, go_s;
    logic                done_r, done_s;
    logic [TIME_W-1:0]   time_r [PLAYERS];
    logic [TIME_W-1:0]   time_s [PLAYERS];
    logic [PLAYERS-1:0]  finished_r, finished_s;
    logic [PLAYERS-1:0]  dq_r, dq_s;
    logic [PLAYERS-1:0]  winner_r, winner_s;
    logic [PLAYERS-1:0]  finish_prev_r;
    logic [PLAYERS-1:0]  rise_s;
    logic                tick_s;
    logic                exit_s;
    logic [PLAYERS-1:0]  best_oh_s;
    logic [TIME_W-1:0]   best_time_s;
    logic                found_s;

`ifndef RACE_TIMER_FALSE_START_EN
    logic launch_unused_s;
    assign launch_unused_s = ^launch;
`endif

    assign tick_s = (div_r == DIV_LAST);
    assign rise_s = finish & ~finish_prev_r;

    // Winner search and race-exit detection over the registered lane state.
    always_comb begin
        best_oh_s   = '0;
        best_time_s = TIME_MAX;
        found_s     = 1'b0;
        exit_s      = 1'b1;
        for (int i = 0; i < PLAYERS; i++) begin
            if (!dq_r[i] && (!found_s || (time_r[i] < best_time_s))) begin
                best_oh_s    = '0;
                best_oh_s[i] = 1'b1;
                best_time_s  = time_r[i];
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
            // A lane still running and not yet saturated keeps the race open;
            // finished or disqualified lanes never hold it open.
            if (!finished_r[i] && !dq_r[i] && (time_r[i] != TIME_MAX)) begin
                exit_s = 1'b0;
            end else begin
                exit_s = exit_s;
            end
        end
    end

    // Next-state and next-output logic for the race sequencer.
    always_comb begin
        state_s    = state_r;
        div_s      = div_r;
        sec_s      = sec_r;
        count_s    = count_r;
        go_s       = 1'b0;
        done_s     = 1'b0;
        time_s     = time_r;
        finished_s = finished_r;
        dq_s       = dq_r;
        winner_s   = winner_r;

        if (abort) begin
            state_s    = ST_IDLE;
            div_s      = '0;
            sec_s      = '0;
            count_s    = 3'd0;
            finished_s = '0;
            dq_s       = '0;
            winner_s   = '0;
            for (int i = 0; i < PLAYERS; i++) begin
                time_s[i] = '0;
            end
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    div_s = '0;
                    if (start) begin
                        state_s    = ST_COUNT;
                        sec_s      = '0;
                        count_s    = COUNT_INIT;
                        finished_s = '0;
                        dq_s       = '0;
                        winner_s   = '0;
                        for (int i = 0; i < PLAYERS; i++) begin
                            time_s[i] = '0;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_COUNT: begin
                    div_s = tick_s ? '0 : div_r + DIV_W'(1);
                    if (tick_s) begin
                        if (sec_r == SEC_LAST) begin
                            sec_s = '0;
                            if (count_r <= 3'd1) begin
                                count_s = 3'd0;
                                go_s    = 1'b1;
                                state_s = ST_RACE;
                                div_s   = '0;
                            end else begin
                                count_s = count_r - 3'd1;
                            end
                        end else begin
                            sec_s = sec_r + SEC_W'(1);
                        end
                    end else begin
                        sec_s = sec_r;
                    end
`ifdef RACE_TIMER_FALSE_START_EN
                    for (int i = 0; i < PLAYERS; i++) begin
                        if (launch[i]) begin
                            dq_s[i]       = 1'b1;
                            finished_s[i] = 1'b1;
                            time_s[i]     = TIME_MAX;
                        end else begin
                            dq_s[i] = dq_r[i];
                        end
                    end
`endif
                end
                ST_RACE: begin
                    div_s = tick_s ? '0 : div_r + DIV_W'(1);
                    if (exit_s) begin
                        // Timed-out lanes are saturated; mark every lane finished.
                        state_s    = ST_DONE;
                        done_s     = 1'b1;
                        div_s      = '0;
                        finished_s = '1;
                        winner_s   = best_oh_s;
                    end else begin
                        for (int i = 0; i < PLAYERS; i++) begin
                            if (finished_r[i]) begin
                                time_s[i] = time_r[i];
                            end else if (rise_s[i]) begin
                                // Finish edge wins over a coincident tick.
                                finished_s[i] = 1'b1;
                            end else if (tick_s && (time_r[i] != TIME_MAX)) begin
                                time_s[i] = time_r[i] + TIME_W'(1);
                            end else begin
                                time_s[i] = time_r[i];
                            end
                        end
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r      <= '0;
            sec_r      <= '0;
            count_r    <= 3'd0;
            go_r       <= 1'b0;
            done_r     <= 1'b0;
            finished_r <= '0;
            dq_r       <= '0;
            winner_r   <= '0;
            for (int i = 0; i < PLAYERS; i++) begin
                time_r[i] <= '0;
            end
        end else begin
            div_r      <= div_s;
            sec_r      <= sec_s;
            count_r    <= count_s;
            go_r       <= go_s;
            done_r     <= done_s;
            finished_r <= finished_s;
            dq_r       <= dq_s;
            winner_r   <= winner_s;
            for (int i = 0; i < PLAYERS; i++) begin
                time_r[i] <= time_s[i];
            end
        end
    end

    // Finish-line edge register; tracks the level in every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            finish_prev_r <= '0;
        end else begin
            finish_prev_r <= finish;
        end
    end

    assign state     = state_r;
    assign count_val = count_r;
    assign go        = go_r;
    assign done      = done_r;
    assign finished  = finished_r;
    assign dq        = dq_r;
    assign winner    = winner_r;

    for (genvar g = 0; g < PLAYERS; g++) begin : g_times
        assign times[g*TIME_W +: TIME_W] = time_r[g];
    end

endmodule

// File: tb/tb_race_timer.sv
// Directed testbench for race_timer with a 10-cycle tick and 2-second countdown.
module tb_race_timer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [1:0]  finish;
    logic [1:0]  launch;
    logic [1:0]  state;
    logic [2:0]  count_val;
    logic        go;
    logic [11:0] times;
    logic [1:0]  finished;
    logic [1:0]  dq;
    logic [1:0]  winner;
    logic        done;
    logic [5:0]  t0;
    logic [5:0]  t1;

    int vec  = 0;
    int miss = 0;

    race_timer #(
        .PLAYERS  (2),
        .CLK_HZ   (100),
        .TICK_HZ  (10),
        .TIME_W   (6),
        .COUNTDOWN(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .finish   (finish),
        .launch   (launch),
        .state    (state),
        .count_val(count_val),
        .go       (go),
        .times    (times),
        .finished (finished),
        .dq       (dq),
        .winner   (winner),
        .done     (done)
    );

    assign t0 = times[5:0];
    assign t1 = times[11:6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse start and run until just after the edge that raises go.
    task automatic run_to_go();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(200);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; finish = 2'b00; launch = 2'b00;
        cyc(2);
        vec++; if (state !== 2'd0) begin miss++; $display("FAIL rst_state act=%0d exp=0", state); end
        vec++; if (count_val !== 3'd0) begin miss++; $display("FAIL rst_count act=%0d exp=0", count_val); end
        vec++; if ({go, done} !== 2'b00) begin miss++; $display("FAIL rst_pulses act=%b exp=00", {go, done}); end
        vec++; if (times !== 12'd0) begin miss++; $display("FAIL rst_times act=%h exp=0", times); end
        vec++; if ({finished, dq, winner} !== 6'd0) begin miss++; $display("FAIL rst_flags act=%b exp=0", {finished, dq, winner}); end
        rst = 1'b0;
        cyc(1);
        vec++; if (state !== 2'd0) begin miss++; $display("FAIL rst_idle act=%0d exp=0", state); end
    endtask

    task automatic test_countdown();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        vec++; if (state !== 2'd1) begin miss++; $display("FAIL cd_state act=%0d exp=1", state); end
        vec++; if (count_val !== 3'd2) begin miss++; $display("FAIL cd_load act=%0d exp=2", count_val); end
        cyc(99);
        vec++; if (count_val !== 3'd2) begin miss++; $display("FAIL cd_pre1 act=%0d exp=2", count_val); end
        cyc(1);
        vec++; if (count_val !== 3'd1) begin miss++; $display("FAIL cd_dec act=%0d exp=1", count_val); end
        cyc(99);
        vec++; if ({state, go} !== {2'd1, 1'b0}) begin miss++; $display("FAIL cd_prego act=%b exp=010", {state, go}); end
        cyc(1);
        vec++; if (go !== 1'b1) begin miss++; $display("FAIL cd_go act=%b exp=1", go); end
        vec++; if (state !== 2'd2) begin miss++; $display("FAIL cd_race act=%0d exp=2", state); end
        vec++; if (count_val !== 3'd0) begin miss++; $display("FAIL cd_zero act=%0d exp=0", count_val); end
        cyc(1);
        vec++; if (go !== 1'b0) begin miss++; $display("FAIL cd_go_pulse act=%b exp=0", go); end
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        vec++; if (state !== 2'd0) begin miss++; $display("FAIL cd_abort act=%0d exp=0", state); end
    endtask

    task automatic test_race();
        run_to_go();
        cyc(34);
        finish = 2'b10;
        cyc(1);
        vec++; if (finished !== 2'b10) begin miss++; $display("FAIL race_fin1 act=%b exp=10", finished); end
        vec++; if (t1 !== 6'd3) begin miss++; $display("FAIL race_t1 act=%0d exp=3", t1); end
        cyc(16);
        finish = 2'b11;
        cyc(1);
        vec++; if (t0 !== 6'd5) begin miss++; $display("FAIL race_t0 act=%0d exp=5", t0); end
        vec++; if ({state, done} !== {2'd2, 1'b0}) begin miss++; $display("FAIL race_predone act=%b exp=100", {state, done}); end
        cyc(1);
        vec++; if ({state, done} !== {2'd3, 1'b1}) begin miss++; $display("FAIL race_done act=%b exp=111", {state, done}); end
        vec++; if (winner !== 2'b10) begin miss++; $display("FAIL race_winner act=%b exp=10", winner); end
        cyc(1);
        finish = 2'b00;
        vec++; if (done !== 1'b0) begin miss++; $display("FAIL race_done_pulse act=%b exp=0", done); end
        vec++; if ({winner, t1, t0} !== {2'b10, 6'd3, 6'd5}) begin miss++; $display("FAIL race_hold act=%b exp=%b", {winner, t1, t0}, {2'b10, 6'd3, 6'd5}); end
    endtask

    task automatic test_tie_collision();
        run_to_go();
        vec++; if ({times, finished, winner} !== 16'd0) begin miss++; $display("FAIL tie_cleared act=%h exp=0", {times, finished, winner}); end
        cyc(39);
        finish = 2'b11;
        cyc(1);
        vec++; if ({t1, t0} !== {6'd3, 6'd3}) begin miss++; $display("FAIL tie_times act=%0d/%0d exp=3/3", t1, t0); end
        vec++; if (finished !== 2'b11) begin miss++; $display("FAIL tie_fin act=%b exp=11", finished); end
        cyc(1);
        vec++; if ({done, winner} !== 3'b101) begin miss++; $display("FAIL tie_winner act=%b exp=101", {done, winner}); end
        finish = 2'b00;
        cyc(1);
    endtask

    task automatic test_timeout();
        run_to_go();
        cyc(630);
        vec++; if ({t1, t0} !== {6'd63, 6'd63}) begin miss++; $display("FAIL to_sat act=%0d/%0d exp=63/63", t1, t0); end
        vec++; if ({state, done, finished} !== {2'd2, 1'b0, 2'b00}) begin miss++; $display("FAIL to_pre act=%b exp=10000", {state, done, finished}); end
        cyc(1);
        vec++; if ({state, done} !== {2'd3, 1'b1}) begin miss++; $display("FAIL to_done act=%b exp=111", {state, done}); end
        vec++; if ({finished, winner} !== 4'b1101) begin miss++; $display("FAIL to_flags act=%b exp=1101", {finished, winner}); end
        cyc(1);
    endtask

    task automatic test_abort();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(199);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        vec++; if ({state, go, count_val} !== 6'd0) begin miss++; $display("FAIL ab_go_supp act=%b exp=0", {state, go, count_val}); end
        run_to_go();
        cyc(25);
        vec++; if (t0 !== 6'd2) begin miss++; $display("FAIL ab_mid_t0 act=%0d exp=2", t0); end
        finish = 2'b01;
        cyc(1);
        vec++; if (finished !== 2'b01) begin miss++; $display("FAIL ab_mid_fin act=%b exp=01", finished); end
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        finish = 2'b00;
        vec++; if ({state, times, finished, winner, count_val} !== 21'd0) begin miss++; $display("FAIL ab_clear act=%h exp=0", {state, times, finished, winner, count_val}); end
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        vec++; if ({state, count_val} !== {2'd1, 3'd2}) begin miss++; $display("FAIL ab_recd act=%b exp=01010", {state, count_val}); end
        cyc(100);
        vec++; if (count_val !== 3'd1) begin miss++; $display("FAIL ab_redec act=%0d exp=1", count_val); end
        cyc(100);
        vec++; if ({state, go} !== {2'd2, 1'b1}) begin miss++; $display("FAIL ab_rego act=%b exp=101", {state, go}); end
        cyc(30);
        vec++; if (t1 !== 6'd3) begin miss++; $display("FAIL rst_mid_t1 act=%0d exp=3", t1); end
        #2;
        rst = 1'b1;
        #1;
        vec++; if ({state, times, finished, go, done} !== 18'd0) begin miss++; $display("FAIL rst_async act=%h exp=0", {state, times, finished, go, done}); end
        #3;
        rst = 1'b0;
        cyc(1);
        vec++; if (state !== 2'd0) begin miss++; $display("FAIL rst_after act=%0d exp=0", state); end
    endtask

`ifdef RACE_TIMER_FALSE_START_EN
    task automatic test_false_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(50);
        launch = 2'b01;
        cyc(1);
        launch = 2'b00;
        vec++; if ({dq, finished} !== 4'b0101) begin miss++; $display("FAIL fs_dq act=%b exp=0101", {dq, finished}); end
        vec++; if (t0 !== 6'd63) begin miss++; $display("FAIL fs_t0 act=%0d exp=63", t0); end
        cyc(149);
        vec++; if ({state, go} !== {2'd2, 1'b1}) begin miss++; $display("FAIL fs_go act=%b exp=101", {state, go}); end
        cyc(14);
        finish = 2'b11;
        cyc(1);
        vec++; if ({t1, finished} !== {6'd1, 2'b11}) begin miss++; $display("FAIL fs_t1 act=%0d/%b exp=1/11", t1, finished); end
        cyc(1);
        vec++; if ({done, winner, dq} !== 5'b11001) begin miss++; $display("FAIL fs_winner act=%b exp=11001", {done, winner, dq}); end
        vec++; if (t0 !== 6'd63) begin miss++; $display("FAIL fs_t0_hold act=%0d exp=63", t0); end
        finish = 2'b00;
        cyc(1);
    endtask
`endif

    initial begin
        test_reset();
        test_countdown();
        test_race();
        test_tie_collision();
        test_timeout();
        test_abort();
`ifdef RACE_TIMER_FALSE_START_EN
        test_false_start();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/race_timer.md
# race_timer

Parametrised N-player race timing engine for the Drag-Racing game. It runs the start countdown, times each lane in centisecond ticks from GO until that player's finish, ranks the winner, and signals end of game. It sits between keyboard/game logic and the scoreboard overlay, replacing the fixed `time_p1`/`time_p2`/`end_game_status` constants with live values. It runs in the 65 MHz pixel clock domain.

## Interface
Parameters:
- `PLAYERS`, 2 — number of lanes, 1..8.
- `CLK_HZ`, 65_000_000 — input clock frequency.
- `TICK_HZ`, 100 — timing resolution; one tick = 1/TICK_HZ s.
- `TIME_W`, 14 — per-player time width; saturates at 2^TIME_W-1.
- `COUNTDOWN`, 3 — countdown length in seconds, 1..7.

Ports:
- `clk` in 1 — 65 MHz clock; all logic on rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `start` in 1 — one-cycle pulse; begins the countdown from IDLE or DONE.
- `abort` in 1 — level; forces IDLE from any state.
- `finish` in PLAYERS — per-lane finish line level; rising edge latches the time.
- `launch` in PLAYERS — per-lane throttle level; used only with the false-start feature.
- `state` out 2 — 0 IDLE, 1 COUNTDOWN, 2 RACE, 3 DONE.
- `count_val` out 3 — seconds remaining in COUNTDOWN; 0 otherwise.
- `go` out 1 — one-cycle pulse on COUNTDOWN→RACE.
- `times` out PLAYERS*TIME_W — lane i occupies bits [i*TIME_W +: TIME_W].
- `finished` out PLAYERS — lane has latched its time.
- `dq` out PLAYERS — lane disqualified; always 0 without the false-start feature.
- `winner` out PLAYERS — one-hot winner, valid in DONE; all-zero if every lane is disqualified.
- `done` out 1 — one-cycle pulse on RACE→DONE.

## Operation
- Reset values:
  - `state`=IDLE.
  - All outputs 0.
  - Tick divider 0.
  - `finish` edge registers 0.
- Tick divider:
  - Counts 0..CLK_HZ/TICK_HZ-1 and emits an internal `tick` on the terminal count.
  - Cleared on every entry to COUNTDOWN and to RACE.
- IDLE:
  - `start` clears `times`/`finished`/`dq`/`winner`, loads `count_val`=COUNTDOWN, and moves to COUNTDOWN.
- COUNTDOWN:
  - A second counter counts TICK_HZ ticks; on each full second `count_val` decrements.
  - When a decrement would reach 0, `count_val` becomes 0, `go` pulses and the state moves to RACE.
- RACE:
  - On each `tick`, every lane with `finished[i]`=0 increments `times[i]`, saturating at all-ones.
  - A rising edge on `finish[i]` (registered previous value 0, current 1) sets `finished[i]` and freezes `times[i]`.
  - If the finish edge and a `tick` occur in the same cycle, the increment is suppressed; the latched time is the pre-tick value.
- RACE exit: the state moves to DONE with `done` pulsed when either condition holds:
  - every lane has `finished[i]|dq[i]`=1, or
  - every unfinished lane has saturated (timeout; those lanes set `finished` with a saturated time).
- `winner`:
  - Computed on the RACE→DONE transition as the minimum `times` among lanes with `dq`=0.
  - Ties resolve to the lowest index.
  - Held through DONE.
- DONE:
  - Outputs held.
  - `start` behaves as in IDLE (restart).
- Edge detection:
  - `finish` edges in IDLE/COUNTDOWN/DONE are ignored.
  - A level already high on entry to RACE does not count; the edge register tracks continuously.
- `abort`:
  - Has priority over `start` and all transitions.
  - Moves to IDLE, clears all outputs, clears the divider.
  - Whichever of `go`/`done` would have fired that cycle is suppressed.
- `start` in COUNTDOWN or RACE is ignored.

## Timing
- First `tick` occurs CLK_HZ/TICK_HZ cycles after entry to COUNTDOWN or RACE.
- `go` is asserted COUNTDOWN*TICK_HZ*CLK_HZ/TICK_HZ cycles after the `start` cycle plus 1 (registered state change).
- A `finish` rising edge sampled at cycle n appears in `finished`/`times` at n+1.
- `done` and `winner` appear in the cycle after the last lane's `finished` becomes 1.
- All outputs are registered; no combinational input→output paths.

## Configuration
- `RACE_TIMER_FALSE_START_EN` defined:
  - `launch[i]`=1 in any COUNTDOWN cycle sets `dq[i]` and `finished[i]`, and sets `times[i]` to all-ones.
  - The lane is excluded from `winner`; its later `finish` edges are ignored.
- Not defined:
  - `launch` is unused.
  - `dq` is tied to 0.
  - Countdown has no effect on lanes.

## Test plan
Bench parameters: CLK_HZ=100, TICK_HZ=10 (tick every 10 cycles), PLAYERS=2, TIME_W=6, COUNTDOWN=2.
- Countdown: `start` at cycle 0 → `count_val` 2, then 1 at cycle 101, `go` pulse and `state`=2 at cycle 201.
- Race: `finish[1]` rises 35 cycles after `go`, `finish[0]` rises 52 cycles after `go` → times 3 and 5; `done` pulse; `winner`=2'b10.
- Tie and tick collision: both finish edges in the same cycle as the 4th tick → both times 3, `winner`=2'b01.
- Timeout: no finish → both times saturate at 63; `finished`=2'b11; `done` fires; `winner`=2'b01.
- `abort` mid-RACE, then `start` → all outputs cleared; new countdown behaves exactly as in the countdown scenario; asserting `rst` mid-RACE gives the same cleared values asynchronously.
- With `RACE_TIMER_FALSE_START_EN`: `launch[0]` pulses during COUNTDOWN → `dq`=2'b01, `times[0]`=63; after lane 1 finishes, `winner`=2'b10.
